// File: rtl/count_bin_sys_pll_pkg.sv
// Shared types and constants for the count_bin system PLL supervisor.
package count_bin_sys_pll_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_t;

    localparam int DEF_SYNC_STAGES         = 2;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 4;

    localparam int LOST_CNT_W = 8;

    // Width of the shared cycle counter: enough to hold (largest period - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/count_bin_sys_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module count_bin_sys_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Synchronizer flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/count_bin_sys_pll_reset_seq.sv
// PLL lock supervisor and system reset sequencer for count_bin.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_PLL_RST   | pulsing pll_rst for PLL_RST_CYCLES, system held in reset
// ST_WAIT_LOCK | waiting for synchronized lock, bounded by the timeout
// ST_STABLE    | lock seen, qualifying it for LOCK_STABLE_CYCLES
// ST_RUN       | system reset released, watching for loss of lock
// ST_FAULT     | retries exhausted, terminal until rst
module count_bin_sys_pll_reset_seq
    import count_bin_sys_pll_pkg::*;
#(
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  pll_locked,
    output logic                  pll_rst,
    output logic                  sys_reset,
    output logic                  pll_fault,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

    localparam int CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

    localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);
    localparam logic [LOST_CNT_W-1:0] LOST_MAX  = '1;

    logic lk;

    pll_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RETRY_W-1:0]      retry_q, retry_d;
    logic [LOST_CNT_W-1:0]   lost_q, lost_d;
    logic                    pll_rst_q, pll_rst_d;
    logic                    sys_reset_q, sys_reset_d;
    logic                    pll_fault_q, pll_fault_d;

    count_bin_sys_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk)
    );

    // Next-state, shared counter, retry/loss bookkeeping and next-state output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        lost_d  = lost_q;

        case (state_q)
            ST_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock wins over a timeout expiring on the same edge.
                if (lk) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LAST) begin
                        state_d = ST_FAULT;
                    end else begin
                        state_d = ST_PLL_RST;
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
            end
            ST_STABLE: begin
                if (!lk) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lk) begin
                    state_d = ST_PLL_RST;
                    if (lost_q != LOST_MAX) lost_d = lost_q + LOST_CNT_W'(1);
                end
            end
            ST_FAULT: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        pll_rst_d   = (state_d == ST_PLL_RST);
        sys_reset_d = (state_d != ST_RUN);
        pll_fault_d = (state_d == ST_FAULT);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            lost_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_reset_q <= 1'b1;
            pll_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            pll_rst_q   <= pll_rst_d;
            sys_reset_q <= sys_reset_d;
            pll_fault_q <= pll_fault_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign sys_reset     = sys_reset_q;
    assign pll_fault     = pll_fault_q;
    assign lock_lost_cnt = lost_q;

endmodule

// File: tb/tb_count_bin_sys_pll_reset_seq.sv
// Directed bench for count_bin_sys_pll_reset_seq with small parameters.
module tb_count_bin_sys_pll_reset_seq;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_reset;
    logic       pll_fault;
    logic [7:0] lock_lost_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic       lock_in;
        logic       exp_pll_rst;
        logic       exp_sys_reset;
        logic       exp_fault;
        logic [7:0] exp_lost;
    } vec_t;

    vec_t vecs[$];

    count_bin_sys_pll_reset_seq #(
        .SYNC_STAGES         (2),
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRIES         (2)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_reset     (sys_reset),
        .pll_fault     (pll_fault),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 refclk = ~refclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Cycle k = outputs after the k-th rising edge following reset release.
    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        chk("reset pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("reset sys_reset", {7'd0, sys_reset}, 8'd1);
        chk("reset pll_fault", {7'd0, pll_fault}, 8'd0);
        chk("reset lock_lost_cnt", lock_lost_cnt, 8'd0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic run_vecs(input string tag);
        foreach (vecs[i]) begin
            pll_locked = vecs[i].lock_in;
            chk({tag, " pll_rst"}, {7'd0, pll_rst}, {7'd0, vecs[i].exp_pll_rst});
            chk({tag, " sys_reset"}, {7'd0, sys_reset}, {7'd0, vecs[i].exp_sys_reset});
            chk({tag, " pll_fault"}, {7'd0, pll_fault}, {7'd0, vecs[i].exp_fault});
            chk({tag, " lock_lost_cnt"}, lock_lost_cnt, vecs[i].exp_lost);
            tick();
        end
    endtask

    task automatic wait_sys(input logic val, input int budget, input string name);
        int n;
        n = 0;
        while (sys_reset !== val && n < budget) begin
            tick();
            n++;
        end
        chk(name, {7'd0, sys_reset}, {7'd0, val});
    endtask

    task automatic fill_clean();
        vec_t v;
        vecs.delete();
        for (int k = 0; k <= 24; k++) begin
            v.lock_in       = (k >= 10);
            v.exp_pll_rst   = (k <= 3);
            v.exp_sys_reset = (k < 21);
            v.exp_fault     = 1'b0;
            v.exp_lost      = 8'd0;
            vecs.push_back(v);
        end
    endtask

    initial begin
        int exp_lost;
        vec_t v;

        // Clean bring-up: lock at cycle 10, release at 21.
        do_reset();
        fill_clean();
        run_vecs("clean");

        // Glitch at cycles 17..19 in STABLE, release 11 after relock (31);
        // then loss in RUN at 36, reset at 39, relock at 40, release at 52.
        do_reset();
        vecs.delete();
        for (int k = 0; k <= 55; k++) begin
            v.lock_in       = (k >= 10) && !(k >= 17 && k <= 19) && !(k >= 36 && k <= 39);
            v.exp_pll_rst   = (k <= 3) || (k >= 39 && k <= 42);
            v.exp_sys_reset = (k < 31) || (k >= 39 && k <= 51);
            v.exp_fault     = 1'b0;
            v.exp_lost      = (k >= 39) ? 8'd1 : 8'd0;
            vecs.push_back(v);
        end
        run_vecs("glitch_loss");

        // Saturation of lock_lost_cnt across 260 loss/relock rounds.
        exp_lost = 1;
        for (int r = 0; r < 260; r++) begin
            pll_locked = 1'b0;
            wait_sys(1'b1, 10, "sat reassert");
            exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
            chk("sat lock_lost_cnt", lock_lost_cnt, 8'(exp_lost));
            pll_locked = 1'b1;
            wait_sys(1'b0, 40, "sat release");
        end
        chk("sat final lock_lost_cnt", lock_lost_cnt, 8'd255);

        // Retry exhaustion: pulses at 0..3 and 36..39, fault from 72.
        do_reset();
        vecs.delete();
        for (int k = 0; k <= 80; k++) begin
            v.lock_in       = 1'b0;
            v.exp_pll_rst   = (k <= 3) || (k >= 36 && k <= 39);
            v.exp_sys_reset = 1'b1;
            v.exp_fault     = (k >= 72);
            v.exp_lost      = 8'd0;
            vecs.push_back(v);
        end
        run_vecs("retry");

        // Fault recovery: async reset mid-cycle clears the fault immediately.
        #2;
        rst = 1'b1;
        #1;
        chk("recover pll_fault", {7'd0, pll_fault}, 8'd0);
        chk("recover pll_rst", {7'd0, pll_rst}, 8'd1);
        chk("recover sys_reset", {7'd0, sys_reset}, 8'd1);
        do_reset();
        fill_clean();
        run_vecs("recover_clean");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_bin_sys_pll_reset_seq.md
# count_bin_sys_pll_reset_seq

PLL lock supervisor and reset sequencer for the count_bin system. It pulses the system PLL's reset and synchronizes the PLL's asynchronous `locked` flag. It releases the downstream system reset only after lock has held continuously for a programmed interval. On loss of lock or lock timeout it re-asserts system reset and retries the PLL, and after a bounded number of failed attempts it latches a fault.

## Interface
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer (≥2).
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles to wait for lock before the attempt counts as failed (≥1).
- `MAX_RETRIES`, 4: failed attempts before fault (≥1).

- `refclk` in 1: free-running 50 MHz reference clock, the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `pll_rst` out 1: reset to the PLL, active-high.
- `sys_reset` out 1: downstream system reset, active-high, synchronous deassertion.
- `pll_fault` out 1: sticky, set when retries are exhausted.
- `lock_lost_cnt` out 8: count of lock losses while in RUN, saturating at 255.

## Operation
- `pll_locked` passes through a `SYNC_STAGES` synchronizer to give `lk`. The FSM uses only `lk`.
- States and transitions:
  - **PLL_RST**: `pll_rst`=1, `sys_reset`=1, and the cycle counter runs. At count `PLL_RST_CYCLES-1` → WAIT_LOCK with the counter cleared.
  - **WAIT_LOCK**: `pll_rst`=0, `sys_reset`=1.
    - `lk`=1 → STABLE with the counter cleared.
    - Otherwise, at count `LOCK_TIMEOUT_CYCLES-1`: if `retry_cnt==MAX_RETRIES-1` → FAULT; else increment `retry_cnt` → PLL_RST.
  - **STABLE**: `sys_reset`=1.
    - `lk`=0 → WAIT_LOCK. The counter clears and the timeout restarts; `retry_cnt` is unchanged.
    - With `lk`=1 at count `LOCK_STABLE_CYCLES-1` → RUN and clear `retry_cnt`.
  - **RUN**: `sys_reset`=0, `pll_rst`=0. `lk`=0 → PLL_RST and increment `lock_lost_cnt` (saturating).
  - **FAULT**: `pll_rst`=0, `sys_reset`=1, `pll_fault`=1. Terminal until `rst`.
- Outputs are registered and decoded from the next state, so each output changes on the same edge as the state.
- Counter width is `$clog2` of the largest of the three cycle parameters. A single counter is shared by all states.

## Timing
- Reset values while `rst`=1:
  - State PLL_RST, counter 0, `retry_cnt` 0.
  - `pll_rst`=1, `sys_reset`=1, `pll_fault`=0, `lock_lost_cnt`=0.
  - Synchronizer flops 0.
- After `rst` falls, `pll_rst` stays high for exactly `PLL_RST_CYCLES` rising edges.
- From a `pll_locked` rise (held) to the `sys_reset` fall: `SYNC_STAGES + 1 + LOCK_STABLE_CYCLES` cycles.
- From a `pll_locked` fall in RUN to `sys_reset` and `pll_rst` rising on the same edge: `SYNC_STAGES + 1` cycles.
- A lock glitch shorter than one cycle may be missed. A glitch captured as `lk`=0 in STABLE always restarts qualification.
- If `lk` rises on the same edge the timeout expires, lock wins and the state goes to STABLE.
- `rst` mid-operation forces reset values immediately, asynchronously. This includes clearing `pll_fault`.
- `lock_lost_cnt` holds at 255.

## Structure
- Package `count_bin_sys_pll_pkg` holds:
  - the FSM state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAULT);
  - the default parameter constants;
  - the `lock_lost_cnt` width constant (8).
- Sub-module `count_bin_sys_bit_sync` is the parameterized `SYNC_STAGES` flop chain with asynchronous reset to 0. The top instantiates it once, for `pll_locked`.

## Test plan
Parameters for all scenarios: `SYNC_STAGES`=2, `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32, `MAX_RETRIES`=2.
- **Clean bring-up.** Release `rst`, then raise `pll_locked` at cycle 10 and hold it. Required: `pll_rst` high for cycles 0–3; `sys_reset` falls at cycle 10+2+1+8=21; `pll_fault`=0.
- **Glitch during qualification.** Drop `pll_locked` for 3 cycles at 4 cycles into STABLE. Required: qualification restarts; `sys_reset` falls 11 cycles after the second rise.
- **Loss of lock in RUN.** Drop `pll_locked` while in RUN. Required: `sys_reset` and `pll_rst` rise 3 cycles later; `lock_lost_cnt` becomes 1; `pll_rst` is held 4 cycles.
- **Retry exhaustion.** Hold `pll_locked`=0 forever. Required: two attempts (`pll_rst` pulses 4 cycles, waits 32), then `pll_fault`=1 with `pll_rst`=0 and `sys_reset`=1, stable forever.
- **Fault recovery.** Assert `rst` asynchronously mid-cycle while in FAULT. Required: `pll_fault` clears and `pll_rst`=1 immediately; a clean bring-up follows.
- **Counter saturation.** Apply 260 lock-loss/relock cycles. Required: `lock_lost_cnt`=255.
